cabac_ctx_init: RTL and testbench
=================================

Name: cabac_ctx_init

Overview:
- Reader and consumer of the 16x64 CABAC context-init ROMs.
- On a slice-start pulse, reads all 64 ROM words in sequence and decodes each into HEVC slope m (signed high byte) and offset n (signed low byte).
- Computes preCtxState = Clip3(1,126,((m*Clip3(0,51,QP))>>4)+n) for each word.
- Writes {pStateIdx, valMps} into the CABAC context RAM. Sits between the ROM bank and the CABAC binarizer/arithmetic coder.

Parameters:
- CTX_NUM, 64, number of contexts initialised per run (ROM depth).
- ADDR_W, 6, ROM and context-RAM address width.
- WORD_W, 16, ROM word width: [15:8] = m, [7:0] = n, both two's complement.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start_i  in  1  one-cycle pulse: begin initialisation
- slice_qp_i  in  6  slice QP, unsigned; sampled on start_i
- rom_en_o  out  1  ROM read enable
- rom_addr_o  out  ADDR_W  ROM read address
- rom_data_i  in  WORD_W  ROM data, valid the cycle after rom_en_o; X otherwise
- ctx_wr_en_o  out  1  context RAM write enable
- ctx_wr_addr_o  out  ADDR_W  context RAM address
- ctx_wr_data_o  out  7  {pStateIdx[5:0], valMps}
- busy_o  out  1  high while a run is in progress
- done_o  out  1  one-cycle pulse after the last write

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE, counters clear, pipeline valids clear. Reset in any state aborts the run, and no further writes occur.
- FSM states:
  - IDLE: on start_i, latch qpc = min(slice_qp_i,51), clear rd_cnt, go to READ.
  - READ: rom_en_o=1, rom_addr_o=rd_cnt, rd_cnt++ each cycle. After addr CTX_NUM-1 is issued, go to DRAIN.
  - DRAIN: wait until the pipeline is empty, pulse done_o, go to IDLE.
- Pipeline is 3 stages, throughput 1 context/cycle:
  - Stage 0: ROM read.
  - Stage 1: rom_data_i valid; compute and register the result.
  - Stage 2: registered outputs drive the context RAM.
- Timing, with start_i in cycle 0:
  - rom_en_o high in cycles 1..64 with addr 0..63.
  - ctx_wr_en_o high in cycles 3..66 with addr 0..63 in order.
  - done_o high in cycle 67.
  - busy_o high in cycles 1..66 (set on the clock edge that accepts start_i).
- Arithmetic:
  - m is signed 8-bit; qpc is 0..51, treated as unsigned 6-bit.
  - Product is signed, at least 15 bits.
  - >>4 is an arithmetic shift (floor toward -inf). Adding n sign-extended gives a signed 11-bit sum.
  - The sum is clipped to 1..126.
  - valMps = (pre > 63). pStateIdx = valMps ? pre-64 : 63-pre.
- rom_data_i is consumed only when the stage-1 valid flag is set. X on rom_data_i at other times must not propagate to any output.
- ctx_wr_addr_o/ctx_wr_data_o hold their last values when ctx_wr_en_o=0.
- start_i while busy_o=1 or done_o=1 is ignored. start_i in the cycle after done_o starts a new run.
- slice_qp_i changes after the start_i cycle have no effect on the current run.

Test Plan:
- Nominal run: behavioural ROM loaded with the production table, qp=26, start at cycle 0.
  - addr0 'h0040 -> write {0,1}, i.e. data 7'h01, in cycle 3.
  - addr2 'hec60 -> pre=63 -> {0,0}.
  - Expect exactly 64 writes in cycles 3..66, addr sequential, done_o in cycle 67.
- qp extremes:
  - qp=0: word 'h0018 -> pre=24 -> {39,0}.
  - qp=51: word 'h0f18 -> 47+24=71 -> {7,1}.
  - qp=60 gives results identical to qp=51.
- Clipping and floor:
  - qp=51, word 'he708 -> floor(-1275/16)=-80, +8=-72 -> clip 1 -> {62,0}.
  - Word 'h0f68 -> 151 -> clip 126 -> {62,1}.
- ROM data sanitisation: drive rom_data_i=X whenever rom_en_o was low in the previous cycle. Outputs stay X-free; busy_o and done_o behave as in the nominal run.
- Control corners:
  - start_i pulsed again in cycle 30 -> ignored, still exactly 64 writes.
  - Back-to-back start in cycle 68 -> second full run.
  - Change slice_qp_i during a run -> no effect on results.
- Reset mid-run: assert rst in cycle 20 for one cycle.
  - Next cycle: all outputs 0, no further writes.
  - A subsequent start_i performs a clean full run.

Source files
------------

// File: rtl/cabac_ctx_init_if.sv
// Bus between the CABAC context initialiser, its ROM bank, the context RAM and the slice controller.
interface cabac_ctx_init_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned WORD_W = 16
);
    logic              start;
    logic [5:0]        slice_qp;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [WORD_W-1:0] rom_data;
    logic              ctx_wr_en;
    logic [ADDR_W-1:0] ctx_wr_addr;
    logic [6:0]        ctx_wr_data;
    logic              busy;
    logic              done;

    // Environment side: controller, ROM bank, context RAM
    modport master (
        output start, slice_qp, rom_data,
        input  rom_en, rom_addr, ctx_wr_en, ctx_wr_addr, ctx_wr_data, busy, done
    );

    // Initialiser side
    modport slave (
        input  start, slice_qp, rom_data,
        output rom_en, rom_addr, ctx_wr_en, ctx_wr_addr, ctx_wr_data, busy, done
    );
endinterface

// File: rtl/cabac_ctx_init.sv
// CABAC context initialiser: streams the context-init ROM, derives preCtxState from slice QP
// and writes {pStateIdx, valMps} into the context RAM at one context per cycle.
module cabac_ctx_init #(
    parameter int unsigned CTX_NUM = 64,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned WORD_W  = 16
) (
    input logic             clk,
    input logic             rst,
    cabac_ctx_init_if.slave bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CTX_NUM - 1);
    localparam logic [5:0]        QP_MAX    = 6'd51;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t            state, state_nx;
    logic [5:0]        qpc, qpc_nx;
    logic              rom_en, rom_en_nx;
    logic [ADDR_W-1:0] rom_addr, rom_addr_nx;
    logic              busy, busy_nx;
    logic              done, done_nx;

    logic              v1;
    logic [ADDR_W-1:0] a1;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [6:0]        wr_data;

    logic [WORD_W-1:0]  word_c;
    logic [7:0]         m_c, n_c;
    logic [14:0]        prod_c;
    logic signed [14:0] prod_s_c, sum_c;
    logic [6:0]         pre_c;
    logic               mps_c;
    logic [5:0]         pst_c;
    logic [6:0]         ctx_c;

    // Control FSM: next state and next values of the registered control outputs
    always_comb begin
        state_nx    = state;
        qpc_nx      = qpc;
        rom_en_nx   = 1'b0;
        rom_addr_nx = rom_addr;
        busy_nx     = busy;
        done_nx     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start && !done) begin
                    qpc_nx      = (bus.slice_qp > QP_MAX) ? QP_MAX : bus.slice_qp;
                    rom_en_nx   = 1'b1;
                    rom_addr_nx = '0;
                    busy_nx     = 1'b1;
                    state_nx    = READ;
                end
            end
            READ: begin
                if (rom_addr == LAST_ADDR) begin
                    state_nx = DRAIN;
                end else begin
                    rom_en_nx   = 1'b1;
                    rom_addr_nx = rom_addr + ADDR_W'(1);
                end
            end
            DRAIN: begin
                // Stage-1 empty means the final write is being presented this cycle
                if (!v1 && !rom_en) begin
                    done_nx  = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Stage 1: decode m/n and map to {pStateIdx, valMps}; gated so idle-bus X never leaks
    always_comb begin
        word_c   = v1 ? bus.rom_data : '0;
        m_c      = word_c[15:8];
        n_c      = word_c[7:0];
        prod_c   = {{7{m_c[7]}}, m_c} * {9'd0, qpc};
        prod_s_c = $signed(prod_c);
        sum_c    = (prod_s_c >>> 4) + $signed({{7{n_c[7]}}, n_c});
        if (sum_c < 15'sd1) begin
            pre_c = 7'd1;
        end else if (sum_c > 15'sd126) begin
            pre_c = 7'd126;
        end else begin
            pre_c = sum_c[6:0];
        end
        mps_c = (pre_c > 7'd63);
        pst_c = mps_c ? 6'(pre_c - 7'd64) : 6'(7'd63 - pre_c);
        ctx_c = {pst_c, mps_c};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            qpc      <= '0;
            rom_en   <= 1'b0;
            rom_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            v1       <= 1'b0;
            a1       <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            state    <= state_nx;
            qpc      <= qpc_nx;
            rom_en   <= rom_en_nx;
            rom_addr <= rom_addr_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            v1       <= rom_en;
            a1       <= rom_addr;
            wr_en    <= v1;
            if (v1) begin
                wr_addr <= a1;
                wr_data <= ctx_c;
            end
        end
    end

    assign bus.rom_en      = rom_en;
    assign bus.rom_addr    = rom_addr;
    assign bus.ctx_wr_en   = wr_en;
    assign bus.ctx_wr_addr = wr_addr;
    assign bus.ctx_wr_data = wr_data;
    assign bus.busy        = busy;
    assign bus.done        = done;
endmodule

// File: tb/tb_cabac_ctx_init.sv
// Randomised self-checking bench for cabac_ctx_init against a cycle-indexed arithmetic model.
module tb_cabac_ctx_init;
    logic clk;
    logic rst;

    cabac_ctx_init_if #(.ADDR_W(6), .WORD_W(16)) bus ();

    cabac_ctx_init #(.CTX_NUM(64), .ADDR_W(6), .WORD_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int         n_chk;
    int         n_fail;
    logic [15:0] rom [64];
    logic [6:0]  got [64];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ROM: one-cycle read latency, undefined data when not enabled
    always @(posedge clk) bus.rom_data <= bus.rom_en ? rom[bus.rom_addr] : 16'hxxxx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // HEVC context init from plain integer arithmetic
    function automatic logic [6:0] ref_ctx(input logic [15:0] w, input int qp);
        int q, m, n, p, t, pre;
        logic [5:0] ps;
        q = (qp > 51) ? 51 : qp;
        m = int'(w[15:8]);
        if (m > 127) m -= 256;
        n = int'(w[7:0]);
        if (n > 127) n -= 256;
        p = m * q;
        if (p >= 0) t = p / 16;
        else        t = -((-p + 15) / 16);
        pre = t + n;
        if (pre < 1)   pre = 1;
        if (pre > 126) pre = 126;
        if (pre > 63) begin
            ps = 6'(pre - 64);
            return {ps, 1'b1};
        end
        ps = 6'(63 - pre);
        return {ps, 1'b0};
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rom_en"},   32'(bus.rom_en), 0);
        chk({tag, "_rom_addr"}, 32'(bus.rom_addr), 0);
        chk({tag, "_wr_en"},    32'(bus.ctx_wr_en), 0);
        chk({tag, "_wr_addr"},  32'(bus.ctx_wr_addr), 0);
        chk({tag, "_wr_data"},  32'(bus.ctx_wr_data), 0);
        chk({tag, "_busy"},     32'(bus.busy), 0);
        chk({tag, "_done"},     32'(bus.done), 0);
    endtask

    task automatic randomize_rom();
        for (int i = 0; i < 64; i++) rom[i] = 16'($urandom);
        rom[0]  = 16'h0040;
        rom[2]  = 16'hec60;
        rom[10] = 16'h0018;
        rom[11] = 16'h0f18;
        rom[12] = 16'he708;
        rom[13] = 16'h0f68;
    endtask

    // Called at a negedge with the DUT idle; start is high during cycle 0
    task automatic do_run(input logic [5:0] qp, input int restart_cyc, input int abort_cyc);
        int nwr;
        logic exp_rd, exp_wr;
        nwr = 0;
        bus.slice_qp = qp;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c <= 67; c++) begin
            if (abort_cyc > 0 && c == abort_cyc + 1) begin
                rst = 1'b0;
                chk_all_zero("abort");
                for (int k = 0; k < 80; k++) begin
                    @(negedge clk);
                    chk("abort_no_wr", 32'(bus.ctx_wr_en), 0);
                    chk("abort_idle",  32'(bus.busy), 0);
                end
                return;
            end
            exp_rd = (c >= 1 && c <= 64);
            exp_wr = (c >= 3 && c <= 66);
            chk("rom_en", 32'(bus.rom_en), 32'(exp_rd));
            if (exp_rd) chk("rom_addr", 32'(bus.rom_addr), 32'(c - 1));
            chk("wr_en", 32'(bus.ctx_wr_en), 32'(exp_wr));
            if (bus.ctx_wr_en) nwr++;
            if (exp_wr) begin
                got[c-3] = bus.ctx_wr_data;
                chk("wr_addr", 32'(bus.ctx_wr_addr), 32'(c - 3));
                chk("wr_data", 32'(bus.ctx_wr_data), 32'(ref_ctx(rom[c-3], int'(qp))));
            end
            chk("busy", 32'(bus.busy), 32'(c <= 66));
            chk("done", 32'(bus.done), 32'(c == 67));
            bus.start    = (c == restart_cyc);
            bus.slice_qp = 6'($urandom);
            rst          = (c == abort_cyc);
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("write_count", 32'(nwr), 64);
    endtask

    initial begin
        n_chk        = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.slice_qp = '0;
        randomize_rom();
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        do_run(6'd26, 30, 0);
        chk("qp26_addr0", 32'(got[0]), 32'h01);
        chk("qp26_addr2", 32'(got[2]), 32'h00);

        do_run(6'd0, 0, 0);
        chk("qp0_0018", 32'(got[10]), 32'h4e);

        do_run(6'd51, 0, 0);
        chk("qp51_0f18", 32'(got[11]), 32'h0f);
        chk("qp51_clip_lo", 32'(got[12]), 32'h7c);
        chk("qp51_clip_hi", 32'(got[13]), 32'h7d);

        do_run(6'd60, 0, 0);
        chk("qp60_0f18", 32'(got[11]), 32'h0f);
        chk("qp60_clip_lo", 32'(got[12]), 32'h7c);
        chk("qp60_clip_hi", 32'(got[13]), 32'h7d);

        do_run(6'($urandom), 0, 20);

        for (int r = 0; r < 3; r++) begin
            randomize_rom();
            do_run(6'($urandom), (r == 0) ? 45 : 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
